// File: rtl/udp_tx_scheduler_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : udp_tx_scheduler_if
// Brief    : Bus bundle between the frame scheduler, the channel word FIFOs and
//            the GMII UDP/IP transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface udp_tx_scheduler_if #(
  parameter int NUM_CH = 2
);
  // channel FIFO side (FWFT heads, levels, pop strobes)
  logic [NUM_CH*16-1:0] ch_level;
  logic [NUM_CH-1:0]    ch_empty;
  logic [NUM_CH*32-1:0] ch_rd_data;
  logic [NUM_CH-1:0]    ch_rd_en;
  // transmitter side
  logic                 tx_start;
  logic [15:0]          tx_data_length;
  logic [15:0]          tx_total_length;
  logic [31:0]          tx_datain;
  logic                 tx_data_req;
  logic [3:0]           tx_state;

  modport master (
    input  ch_level, ch_empty, ch_rd_data, tx_data_req, tx_state,
    output ch_rd_en, tx_start, tx_data_length, tx_total_length, tx_datain
  );

  modport slave (
    output ch_level, ch_empty, ch_rd_data, tx_data_req, tx_state,
    input  ch_rd_en, tx_start, tx_data_length, tx_total_length, tx_datain
  );
endinterface
`default_nettype wire

// File: rtl/udp_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : udp_tx_scheduler
// Brief    : Round-robin frame scheduler feeding the GMII UDP/IP transmitter
//            from NUM_CH word FIFOs, with inter-frame gap and hang watchdog.
//            Optional macro SEQ_HDR_EN prepends a {grant_id, frame_cnt} word.
// Revision : 1.0 - initial release
// ============================================================================
module udp_tx_scheduler #(
  parameter int NUM_CH         = 2,
  parameter int PAYLOAD_WORDS  = 256,
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  udp_tx_scheduler_if.master bus,
  output logic               busy,
  output logic [1:0]         grant_id,
  output logic [31:0]        frame_cnt,
  output logic               err_underflow,
  output logic               err_timeout
);

`ifdef SEQ_HDR_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam int          W         = PAYLOAD_WORDS + int'(HDR_EN);
  localparam logic [15:0] DATA_LEN  = 16'(4 * W + 8);
  localparam logic [15:0] TOTAL_LEN = 16'(4 * W + 28);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ARB       = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_IFG       = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        rr_q, rr_d;
  logic [15:0]       dlen_q, dlen_d;
  logic [15:0]       tlen_q, tlen_d;
  logic [31:0]       frame_cnt_q, frame_cnt_d;
  logic [31:0]       wdog_q, wdog_d;
  logic [31:0]       ifg_q, ifg_d;
  logic              err_to_q, err_to_d;
  logic              err_uf_q, err_uf_d;
  logic [31:0]       datain_q, datain_d;
  logic [NUM_CH-1:0] rd_en_q, rd_en_d;
  logic [15:0]       words_q, words_d;
  logic              req_q, req_d;

  logic [NUM_CH-1:0] elig;
  logic              arb_found;
  logic [1:0]        arb_idx;
  logic [1:0]        rr_next;
  logic [2:0]        cand;
  logic [31:0]       head_word;
  logic              head_empty;
  logic [31:0]       hdr_word;
  logic              in_frame;
  logic              req_rise;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_elig
    assign elig[k] = (bus.ch_level[16*k +: 16] >= 16'(W)) && !bus.ch_empty[k];
  end

  // First eligible channel at or after the round-robin pointer, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = 2'd0;
    cand      = 3'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = {1'b0, rr_q} + 3'(i);
      if (cand >= 3'(NUM_CH)) begin
        cand = cand - 3'(NUM_CH);
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (!arb_found && (cand == 3'(k)) && elig[k]) begin
          arb_found = 1'b1;
          arb_idx   = 2'(k);
        end
      end
    end
    rr_next = (arb_idx == 2'(NUM_CH - 1)) ? 2'd0 : arb_idx + 2'd1;
  end

  always_comb begin
    head_word  = 32'd0;
    head_empty = 1'b1;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_q == 2'(k)) begin
        head_word  = bus.ch_rd_data[32*k +: 32];
        head_empty = bus.ch_empty[k];
      end
    end
  end

  assign hdr_word = {6'b0, grant_q, frame_cnt_q[23:0]};
  assign in_frame = (state_q == S_START) || (state_q == S_WAIT_BUSY) ||
                    (state_q == S_WAIT_DONE);
  assign req_rise = bus.tx_data_req && !req_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 2'd0;
      rr_q        <= 2'd0;
      dlen_q      <= 16'd0;
      tlen_q      <= 16'd0;
      frame_cnt_q <= 32'd0;
      wdog_q      <= 32'd0;
      ifg_q       <= 32'd0;
      err_to_q    <= 1'b0;
      err_uf_q    <= 1'b0;
      datain_q    <= 32'd0;
      rd_en_q     <= '0;
      words_q     <= 16'd0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_q        <= rr_d;
      dlen_q      <= dlen_d;
      tlen_q      <= tlen_d;
      frame_cnt_q <= frame_cnt_d;
      wdog_q      <= wdog_d;
      ifg_q       <= ifg_d;
      err_to_q    <= err_to_d;
      err_uf_q    <= err_uf_d;
      datain_q    <= datain_d;
      rd_en_q     <= rd_en_d;
      words_q     <= words_d;
      req_q       <= req_d;
    end
  end

  // Next-state and control
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    dlen_d      = dlen_q;
    tlen_d      = tlen_q;
    frame_cnt_d = frame_cnt_q;
    wdog_d      = wdog_q;
    ifg_d       = ifg_q;
    err_to_d    = err_to_q;
    case (state_q)
      S_IDLE: begin
        if (en && (|elig)) begin
          state_d = S_ARB;
        end
      end
      S_ARB: begin
        if (arb_found) begin
          grant_d = arb_idx;
          rr_d    = rr_next;
          dlen_d  = DATA_LEN;
          tlen_d  = TOTAL_LEN;
          wdog_d  = 32'd0;
          state_d = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        // A hung transmitter abandons the frame without counting it.
        if (wdog_q == 32'(TIMEOUT_CYCLES - 1)) begin
          err_to_d = 1'b1;
          state_d  = S_IDLE;
        end else begin
          wdog_d = wdog_q + 32'd1;
          if (state_q == S_WAIT_BUSY) begin
            if (bus.tx_state != 4'h0) begin
              state_d = S_WAIT_DONE;
            end
          end else if (bus.tx_state == 4'h0) begin
            frame_cnt_d = frame_cnt_q + 32'd1;
            ifg_d       = 32'd0;
            state_d     = S_IFG;
          end
        end
      end
      S_IFG: begin
        if (ifg_q == 32'(IFG_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          ifg_d = ifg_q + 32'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Data path: one word per request edge, pops capped at the frame size.
  always_comb begin
    datain_d = datain_q;
    rd_en_d  = '0;
    words_d  = words_q;
    err_uf_d = err_uf_q;
    req_d    = bus.tx_data_req;
    if (state_q == S_ARB) begin
      words_d = 16'd0;
    end else if (req_rise && in_frame) begin
      if (words_q < 16'(W)) begin
        words_d = words_q + 16'd1;
        if (HDR_EN && (words_q == 16'd0)) begin
          datain_d = hdr_word;
        end else if (head_empty) begin
          datain_d = 32'd0;
          err_uf_d = 1'b1;
        end else begin
          datain_d = head_word;
          for (int k = 0; k < NUM_CH; k++) begin
            rd_en_d[k] = (grant_q == 2'(k));
          end
        end
      end
    end
  end

  // Outputs
  always_comb begin
    bus.tx_start = (state_q == S_START);
    busy         = (state_q != S_IDLE);
  end

  assign bus.ch_rd_en        = rd_en_q;
  assign bus.tx_data_length  = dlen_q;
  assign bus.tx_total_length = tlen_q;
  assign bus.tx_datain       = datain_q;
  assign grant_id            = grant_q;
  assign frame_cnt           = frame_cnt_q;
  assign err_underflow       = err_uf_q;
  assign err_timeout         = err_to_q;

endmodule
`default_nettype wire

// File: tb/tb_udp_tx_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_udp_tx_scheduler
// Brief    : Randomized bench for udp_tx_scheduler with FIFO/transmitter
//            models and a frame-level reference (grant order, words, counts).
// Revision : 1.0 - initial release
// ============================================================================
module tb_udp_tx_scheduler;
  localparam int NUM_CH = 3;
  localparam int PW     = 256;
  localparam int IFG    = 12;
  localparam int TO     = 4096;
`ifdef SEQ_HDR_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int W = PW + HDR;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        busy;
  logic [1:0]  grant_id;
  logic [31:0] frame_cnt;
  logic        err_underflow;
  logic        err_timeout;

  udp_tx_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

  udp_tx_scheduler #(
    .NUM_CH(NUM_CH), .PAYLOAD_WORDS(PW), .IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus), .busy(busy),
    .grant_id(grant_id), .frame_cnt(frame_cnt),
    .err_underflow(err_underflow), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  logic [31:0]       fq [NUM_CH][$];
  logic [NUM_CH-1:0] force_empty;
  int                m_rr;
  logic [31:0]       m_fc;
  logic              m_uf;
  int                last_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drive_fifos();
    for (int k = 0; k < NUM_CH; k++) begin
      bus.ch_level[16*k +: 16]   = 16'(fq[k].size());
      bus.ch_empty[k]            = (fq[k].size() == 0) || force_empty[k];
      bus.ch_rd_data[32*k +: 32] = (fq[k].size() > 0) ? fq[k][0] : 32'h0;
    end
  endtask

  task automatic fill(input int k, input int n);
    for (int i = 0; i < n; i++) fq[k].push_back($urandom());
    drive_fifos();
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b1;
    bus.tx_data_req = 1'b0; bus.tx_state = 4'h0;
    force_empty = '0;
    for (int k = 0; k < NUM_CH; k++) fq[k].delete();
    drive_fifos();
    repeat (3) tick();
    rst = 1'b0;
    m_rr = 0; m_fc = 32'd0; m_uf = 1'b0; last_drop = -1;
  endtask

  task automatic check_zero(input string p);
    check({p, "_tx_start"},  32'(bus.tx_start), 32'd0);
    check({p, "_data_len"},  32'(bus.tx_data_length), 32'd0);
    check({p, "_total_len"}, 32'(bus.tx_total_length), 32'd0);
    check({p, "_datain"},    bus.tx_datain, 32'd0);
    check({p, "_rd_en"},     32'(bus.ch_rd_en), 32'd0);
    check({p, "_busy"},      32'(busy), 32'd0);
    check({p, "_grant"},     32'(grant_id), 32'd0);
    check({p, "_frame_cnt"}, frame_cnt, 32'd0);
    check({p, "_err_uf"},    32'(err_underflow), 32'd0);
    check({p, "_err_to"},    32'(err_timeout), 32'd0);
  endtask

  task automatic wait_start(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (bus.ch_rd_en != '0) check("stray_pop_idle", 32'(bus.ch_rd_en), 32'd0);
      if (bus.tx_start) seen = 1'b1;
    end
    if (!seen) check("start_seen", 32'd0, 32'd1);
  endtask

  // One frame: predict the grant from queue depths, act as the transmitter,
  // and score every delivered word against the channel's stored contents.
  task automatic serve_frame(input int extra, input int force_after, input bit drop_en);
    bit seen, any;
    int g, sent, pops;
    logic [31:0] exp, last, hdr;
    logic [NUM_CH-1:0] exp_en;
    g = -1;
    for (int i = 0; i < NUM_CH; i++)
      if (g < 0 && fq[(m_rr + i) % NUM_CH].size() >= W) g = (m_rr + i) % NUM_CH;
    if (g < 0) begin
      check("setup_has_eligible", 32'd0, 32'd1);
      return;
    end
    wait_start(200, seen);
    if (!seen) return;
    check("grant_id", 32'(grant_id), 32'(g));
    check("data_len", 32'(bus.tx_data_length), 32'(4 * W + 8));
    check("total_len", 32'(bus.tx_total_length), 32'(4 * W + 28));
    check("frame_cnt_at_start", frame_cnt, m_fc);
    if (last_drop >= 0) check("ifg_gap_ok", 32'(cyc - last_drop >= IFG + 3), 32'd1);
    m_rr = (g + 1) % NUM_CH;
    if (drop_en) en = 1'b0;
    tick();
    check("start_pulse_width", 32'(bus.tx_start), 32'd0);
    repeat ($urandom_range(0, 2)) tick();
    bus.tx_state = 4'($urandom_range(1, 15));
    hdr  = {6'b0, 2'(g), m_fc[23:0]};
    sent = 0; pops = 0; last = 32'd0;
    for (int r = 0; r < W + extra; r++) begin
      bus.tx_data_req = 1'b1;
      tick();
      bus.tx_data_req = 1'b0;
      exp_en = '0;
      if (sent < W) begin
        if (HDR == 1 && sent == 0) exp = hdr;
        else if (force_empty[g] || fq[g].size() == 0) begin
          exp  = 32'd0;
          m_uf = 1'b1;
        end else begin
          exp       = fq[g][0];
          exp_en[g] = 1'b1;
        end
        sent++;
      end else begin
        exp = last;
      end
      check("tx_datain", bus.tx_datain, exp);
      check("rd_en", 32'(bus.ch_rd_en), 32'(exp_en));
      if (exp_en != '0) begin
        void'(fq[g].pop_front());
        pops++;
      end
      last = exp;
      if (force_after >= 0 && pops == force_after) force_empty[g] = 1'b1;
      drive_fifos();
      repeat ($urandom_range(1, 3)) begin
        tick();
        if (bus.ch_rd_en != '0) check("stray_pop", 32'(bus.ch_rd_en), 32'd0);
      end
    end
    repeat ($urandom_range(0, 2)) tick();
    check("busy_in_frame", 32'(busy), 32'd1);
    bus.tx_state = 4'h0;
    last_drop = cyc;
    m_fc = m_fc + 32'd1;
    force_empty = '0;
    drive_fifos();
    tick();
    check("frame_cnt", frame_cnt, m_fc);
    check("err_underflow", 32'(err_underflow), 32'(m_uf));
    check("pops_per_frame", 32'(pops), 32'(force_after >= 0 ? force_after : PW));
    check("busy_ifg", 32'(busy), 32'd1);
    if (drop_en) begin
      any = 1'b0;
      repeat (40) begin
        tick();
        if (bus.tx_start) any = 1'b1;
      end
      check("en_low_blocks_start", 32'(any), 32'd0);
      en = 1'b1;
    end
  endtask

  initial begin
    bit seen, done, any;
    int t0, k;

    // reset values
    apply_reset();
    check_zero("reset");

    // single channel at exactly W; ch2 one word short stays ineligible
    fill(0, W);
    fill(2, W - 1);
    serve_frame(0, -1, 1'b0);

    // reset while the transmitter is mid-frame
    fill(0, W);
    wait_start(200, seen);
    bus.tx_state = 4'h3;
    repeat (5) begin
      bus.tx_data_req = 1'b1; tick();
      bus.tx_data_req = 1'b0; tick();
    end
    bus.tx_data_req = 1'b1;
    rst = 1'b1;
    tick();
    check_zero("rst_mid");
    rst = 1'b0;
    bus.tx_data_req = 1'b0;
    bus.tx_state = 4'h0;
    for (int j = 0; j < NUM_CH; j++) fq[j].delete();
    drive_fifos();
    any = 1'b0;
    repeat (20) begin
      tick();
      if (bus.ch_rd_en != '0 || busy) any = 1'b1;
    end
    check("post_rst_quiet", 32'(any), 32'd0);

    // two channels continuously eligible alternate
    apply_reset();
    fill(0, 4 * W);
    fill(1, 4 * W);
    for (int i = 0; i < 4; i++) begin
      serve_frame($urandom_range(0, 2), -1, 1'b0);
      check("alt_grant", 32'(grant_id), 32'(i % 2));
    end

    // granted FIFO runs dry after 100 pops
    apply_reset();
    fill(0, W);
    serve_frame(0, 100, 1'b0);

    // transmitter hangs after start
    apply_reset();
    fill(0, W);
    wait_start(200, seen);
    t0 = cyc;
    bus.tx_state = 4'h5;
    done = 1'b0;
    for (int i = 0; i < TO + 100 && !done; i++) begin
      tick();
      if (!busy) done = 1'b1;
    end
    check("timeout_reached", 32'(done), 32'd1);
    check("timeout_cycles_ok", 32'((cyc - t0 >= TO) && (cyc - t0 <= TO + 2)), 32'd1);
    check("err_timeout", 32'(err_timeout), 32'd1);
    check("timeout_frame_cnt", frame_cnt, 32'd0);

    // randomized traffic
    apply_reset();
    for (int f = 0; f < 8; f++) begin
      any = 1'b0;
      for (int j = 0; j < NUM_CH; j++) if (fq[j].size() >= W) any = 1'b1;
      if (!any) begin
        k = $urandom_range(0, NUM_CH - 1);
        fill(k, W + $urandom_range(0, 40));
      end
      serve_frame($urandom_range(0, 2), -1, ($urandom_range(0, 3) == 0));
      for (int j = 0; j < NUM_CH; j++)
        if ($urandom_range(0, 1) == 1) fill(j, $urandom_range(0, W + 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "simulation time limit");
  end

endmodule
`default_nettype wire
